// File: rtl/bs_pkg.sv
// Shared definitions for the pipelined barrel shifter: mode encodings and
// the per-stage control payload that travels alongside the data word.
package bs_pkg;

   localparam logic [2:0] MODE_SLL = 3'd0;
   localparam logic [2:0] MODE_SRL = 3'd1;
   localparam logic [2:0] MODE_SRA = 3'd2;
   localparam logic [2:0] MODE_ROL = 3'd3;
   localparam logic [2:0] MODE_ROR = 3'd4;

   // sign is the operand MSB captured at input; SRA fills from it in every stage
   typedef struct packed {
      logic [2:0] mode;
      logic       sign;
   } bs_ctrl_t;

   localparam int CTRL_W = $bits(bs_ctrl_t);

endpackage

// File: rtl/barrel_stage.sv
// One shift level: conditional shift by a fixed DIST in any mode, followed by
// the stage register and its load/ready decision.
module barrel_stage
   import bs_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH),
   parameter int DIST  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic [SHW-1:0]   amt_i,
   input  bs_ctrl_t         ctrl_i,
   input  logic             dn_load_i,
   output logic             load_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o,
   output logic [SHW-1:0]   amt_o,
   output bs_ctrl_t         ctrl_o,
   output logic             zero_o
);

   localparam int BIT = $clog2(DIST);

   logic [WIDTH-1:0] shifted;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [SHW-1:0]   amt_q, amt_d;
   bs_ctrl_t         ctrl_q, ctrl_d;
   logic             zero_q, zero_d;

   always_comb begin
      shifted = data_i;
      if (amt_i[BIT]) begin
         case (ctrl_i.mode)
            MODE_SLL: shifted = {data_i[WIDTH-1-DIST:0], {DIST{1'b0}}};
            MODE_SRL: shifted = {{DIST{1'b0}}, data_i[WIDTH-1:DIST]};
            MODE_SRA: shifted = {{DIST{ctrl_i.sign}}, data_i[WIDTH-1:DIST]};
            MODE_ROL: shifted = {data_i[WIDTH-1-DIST:0], data_i[WIDTH-1:WIDTH-DIST]};
            MODE_ROR: shifted = {data_i[DIST-1:0], data_i[WIDTH-1:DIST]};
            default:  shifted = data_i;
         endcase
      end
   end

   assign load_o = !valid_q || dn_load_i;

   // Payload only moves with a valid word, so a bubble never disturbs the
   // held data and the output register stays stable across empty slots.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      amt_d   = amt_q;
      ctrl_d  = ctrl_q;
      zero_d  = zero_q;
      if (load_o) begin
         valid_d = valid_i;
         if (valid_i) begin
            data_d = shifted;
            amt_d  = amt_i;
            ctrl_d = ctrl_i;
            zero_d = ~|shifted;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         amt_q   <= '0;
         ctrl_q  <= '0;
         zero_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         amt_q   <= amt_d;
         ctrl_q  <= ctrl_d;
         zero_q  <= zero_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign amt_o   = amt_q;
   assign ctrl_o  = ctrl_q;
   assign zero_o  = zero_q;

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: SHW registered shift levels, largest distance
// first, with a ready chain that lets bubbles collapse under backpressure.
module barrel_shifter_pipe
   import bs_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_amt,
   input  logic [2:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_zero
);

   // index k is the input of stage k; index SHW is the last stage's output
   logic     [SHW:0]            valid_s;
   logic     [SHW:0][WIDTH-1:0] data_s;
   logic     [SHW:0][SHW-1:0]   amt_s;
   bs_ctrl_t [SHW:0]            ctrl_s;
   logic     [SHW:0]            load_s;
   logic     [SHW-1:0]          zero_s;

   assign valid_s[0]     = in_valid && !rst;
   assign data_s[0]      = in_data;
   assign amt_s[0]       = in_amt;
   assign ctrl_s[0].mode = in_mode;
   assign ctrl_s[0].sign = in_data[WIDTH-1];
   assign load_s[SHW]    = out_ready;

   for (genvar k = 0; k < SHW; k++) begin : g_stage
      barrel_stage #(
         .WIDTH (WIDTH),
         .SHW   (SHW),
         .DIST  (1 << (SHW-1-k))
      ) u_stage (
         .clk       (clk),
         .rst       (rst),
         .valid_i   (valid_s[k]),
         .data_i    (data_s[k]),
         .amt_i     (amt_s[k]),
         .ctrl_i    (ctrl_s[k]),
         .dn_load_i (load_s[k+1]),
         .load_o    (load_s[k]),
         .valid_o   (valid_s[k+1]),
         .data_o    (data_s[k+1]),
         .amt_o     (amt_s[k+1]),
         .ctrl_o    (ctrl_s[k+1]),
         .zero_o    (zero_s[k])
      );
   end

   assign in_ready  = load_s[0] && !rst;
   assign out_valid = valid_s[SHW];
   assign out_data  = data_s[SHW];
   assign out_zero  = zero_s[SHW-1];

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Scoreboard bench for barrel_shifter_pipe at WIDTH=16: directed vectors,
// backpressure, random streaming and mid-flight reset.
module tb_barrel_shifter_pipe;

   localparam int W = 16;
   localparam int S = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic [S-1:0] in_amt;
   logic [2:0]   in_mode;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         out_zero;

   logic rand_rdy = 1'b0;
   logic rnd_rdy  = 1'b1;
   logic rdy_man  = 1'b1;
   assign out_ready = rand_rdy ? rnd_rdy : rdy_man;

   barrel_shifter_pipe #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_zero  (out_zero)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      rnd_rdy = 1'($urandom_range(0, 1));
   end

   typedef struct {
      logic [W-1:0] data;
      logic         zero;
      bit           lat;
      int           acc;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input logic [S-1:0] a,
                                              input logic [2:0] m);
      logic [2*W-1:0] t;
      case (m)
         3'd0: return d << a;
         3'd1: return d >> a;
         3'd2: return W'($signed(d) >>> a);
         3'd3: begin t = {d, d} << a; return t[2*W-1:W]; end
         3'd4: begin t = {d, d} >> a; return t[W-1:0]; end
         default: return d;
      endcase
   endfunction

   // Monitor: every presented result is compared to the queue head; the head
   // is popped only on an actual output transfer, so stalls are re-checked.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (q.size() == 0) begin
            chk("unexpected_output", {15'd0, out_valid, out_data}, 32'd0);
         end else begin
            chk("out_data", {16'd0, out_data}, {16'd0, q[0].data});
            chk("out_zero", {31'd0, out_zero}, {31'd0, q[0].zero});
            if (out_ready) begin
               if (q[0].lat) chk("latency", cyc - q[0].acc, S);
               void'(q.pop_front());
            end
         end
      end
   end

   task automatic push_exp(input logic [W-1:0] e, input bit lat);
      exp_t x;
      x.data = e;
      x.zero = (e == '0);
      x.lat  = lat;
      x.acc  = cyc;
      q.push_back(x);
   endtask

   // Leaves in_valid high so consecutive calls issue back-to-back.
   task automatic send(input logic [W-1:0] d, input logic [S-1:0] a, input logic [2:0] m,
                       input logic [W-1:0] e, input bit lat);
      bit done = 0;
      int n = 0;
      in_valid = 1'b1; in_data = d; in_amt = a; in_mode = m;
      while (!done) begin
         @(negedge clk);
         if (in_ready) begin
            push_exp(e, lat);
            done = 1;
         end
         @(posedge clk); #1;
         n++;
         if (!done && n > 300) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: in_ready never rose for %0h", d);
            done = 1;
         end
      end
   endtask

   task automatic drain();
      int n = 0;
      in_valid = 1'b0;
      rand_rdy = 1'b0;
      rdy_man  = 1'b1;
      while ((q.size() != 0 || out_valid) && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_done", q.size(), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_mode = '0;
      @(negedge clk);
      chk("rst_in_ready", {31'd0, in_ready}, 0);
      @(negedge clk);
      chk("rst_out_valid", {31'd0, out_valid}, 0);
      chk("rst_out_data", {16'd0, out_data}, 0);
      chk("rst_out_zero", {31'd0, out_zero}, 0);
      chk("rst_in_ready2", {31'd0, in_ready}, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // directed vectors, back-to-back with no backpressure
      send(16'h00FF, 4'd8,  3'b000, 16'hFF00, 1);
      send(16'h8000, 4'd3,  3'b010, 16'hF000, 1);
      send(16'hF000, 4'd15, 3'b001, 16'h0001, 1);
      send(16'h0001, 4'd1,  3'b001, 16'h0000, 1);
      send(16'h8001, 4'd4,  3'b011, 16'h0018, 1);
      send(16'h8001, 4'd4,  3'b100, 16'h1800, 1);
      send(16'h1234, 4'd5,  3'b111, 16'h1234, 1);
      send(16'hABCD, 4'd0,  3'b010, 16'hABCD, 1);
      send(16'h8421, 4'd0,  3'b011, 16'h8421, 1);
      send(16'h8000, 4'd15, 3'b010, 16'hFFFF, 1);
      drain();

      // backpressure: four fill the pipe, the fifth waits for the first to leave
      rdy_man  = 1'b0;
      in_valid = 1'b1; in_mode = 3'b000; in_data = 16'h0001;
      for (int i = 0; i < 5; i++) begin
         in_amt = S'(i + 1);
         @(negedge clk);
         if (i < 4) begin
            chk("bp_accept", {31'd0, in_ready}, 1);
            if (in_ready) push_exp(16'h0001 << (i + 1), 0);
         end else begin
            chk("bp_full", {31'd0, in_ready}, 0);
         end
         @(posedge clk); #1;
      end
      repeat (2) begin
         @(negedge clk);
         chk("bp_still_full", {31'd0, in_ready}, 0);
         @(posedge clk); #1;
      end
      rdy_man = 1'b1;
      @(negedge clk);
      chk("bp_same_cycle", {31'd0, in_ready}, 1);
      if (in_ready) push_exp(16'h0020, 0);
      @(posedge clk); #1;
      drain();

      // random streaming with random out_ready
      rand_rdy = 1'b1;
      for (int i = 0; i < 100; i++) begin
         logic [W-1:0] d;
         logic [S-1:0] a;
         logic [2:0]   m;
         d = W'($urandom);
         a = S'($urandom_range(0, 15));
         m = 3'($urandom_range(0, 7));
         send(d, a, m, ref_shift(d, a, m), 0);
      end
      drain();

      // reset with three operations in flight
      send(16'h0F0F, 4'd4, 3'b000, 16'hF0F0, 0);
      send(16'h00F0, 4'd4, 3'b001, 16'h000F, 0);
      send(16'h1111, 4'd1, 3'b011, 16'h2222, 0);
      in_valid = 1'b0;
      rst = 1'b1;
      q.delete();
      @(negedge clk);
      chk("midrst_in_ready", {31'd0, in_ready}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      in_valid = 1'b1; in_data = 16'h0003; in_amt = 4'd2; in_mode = 3'b000;
      @(negedge clk);
      chk("midrst_out_valid", {31'd0, out_valid}, 0);
      chk("midrst_out_data", {16'd0, out_data}, 0);
      chk("midrst_out_zero", {31'd0, out_zero}, 0);
      chk("post_rst_accept", {31'd0, in_ready}, 1);
      if (in_ready) push_exp(16'h000C, 1);
      @(posedge clk); #1;
      drain();
      repeat (4) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
